label_prescan: RTL and testbench

Label prescan and lookup unit for the OSECPU core. After reset it walks instruction memory once, records every LBSET target in a label table, then releases the instruction controller. During execution it resolves PLIMM label operands into program-counter update requests. It sits beside the controller: upstream of it during prescan, since it owns the memory address bus and holds the core in reset, and downstream during execution, since it consumes the executing instruction and feeds `pc_update_req`/`pc_update_addr` back.

---
 rtl/label_prescan_pkg.sv | 24 ++
 rtl/label_prescan_table.sv | 41 ++++
 rtl/label_prescan.sv | 139 +++++++++++++
 tb/tb_label_prescan.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/label_prescan_pkg.sv
// Shared opcode and prescan FSM definitions for the OSECPU label prescan unit.
package label_prescan_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LBSET  = 8'h01;
    localparam logic [7:0] OP_LIMM32 = 8'h02;
    localparam logic [7:0] OP_PLIMM  = 8'h03;
    localparam logic [7:0] OP_HLT    = 8'hFF;

    typedef enum logic [2:0] {
        S_RESET,
        S_ADDR,
        S_WORD0,
        S_SKIP_ADDR,
        S_SKIP_DATA,
        S_DONE
    } scan_state_t;

    // Opcodes followed by an immediate word that must not be decoded.
    function automatic logic is_two_word(input logic [7:0] op);
        return (op == OP_LIMM32) || (op == OP_LBSET);
    endfunction

endpackage

// File: rtl/label_prescan_table.sv
// Label table: one synchronous write port, one asynchronous read port, resettable valid bits.
module label_table
    import label_prescan_pkg::*;
#(
    parameter int LABEL_W = 8,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LABEL_W-1:0] wr_id,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [LABEL_W-1:0] rd_id,
    output logic               rd_valid,
    output logic [ADDR_W-1:0]  rd_addr
);

    localparam int ENTRIES = 2 ** LABEL_W;

    logic [ADDR_W-1:0]  entries [ENTRIES];
    logic [ENTRIES-1:0] valid;

    // Only the valid bits are cleared; stale targets are unreachable once invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_id] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entries[wr_id] <= wr_addr;
        end
    end

    assign rd_valid = valid[rd_id];
    assign rd_addr  = entries[rd_id];

endmodule

// File: rtl/label_prescan.sv
// Walks instruction memory once after reset to record LBSET targets, then
// resolves PLIMM label operands into PC update requests during execution.
module label_prescan
    import label_prescan_pkg::*;
#(
    parameter int LABEL_W   = 8,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 4096
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [31:0]        memdata,
    output logic               scan_done,
    output logic               cpu_reset,
    input  logic               exec_valid,
    input  logic [31:0]        instr0,
    output logic               pc_update_req,
    output logic [ADDR_W-1:0]  pc_update_addr,
    output logic [LABEL_W:0]   label_count,
    output logic               err_dup,
    output logic               err_undef
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(MEM_DEPTH - 1);

    scan_state_t        state;
    scan_state_t        next_state;
    logic [ADDR_W-1:0]  scan_ptr;
    logic [ADDR_W-1:0]  ptr_next;
    logic [ADDR_W:0]    ptr_plus2;

    logic [7:0]         scan_op;
    logic [7:0]         exec_op;
    logic               lookup;
    logic               lbset_seen;
    logic               wr_en;
    logic [LABEL_W-1:0] rd_id;
    logic               rd_valid;
    logic [ADDR_W-1:0]  rd_addr;
    logic               unused_bits;

    assign scan_op     = memdata[31:24];
    assign exec_op     = instr0[31:24];
    assign ptr_plus2   = {1'b0, scan_ptr} + (ADDR_W + 1)'(2);
    assign unused_bits = ^{memdata[23:LABEL_W], instr0[23:LABEL_W]};

    assign scan_done = (state == S_DONE);
    assign cpu_reset = reset | ~scan_done;
    assign mem_addr  = (state == S_SKIP_ADDR) ? scan_ptr + ADDR_W'(1) : scan_ptr;

    // The single read port serves the duplicate check while scanning and the
    // PLIMM lookup afterwards; the two uses never overlap.
    assign rd_id      = scan_done ? instr0[LABEL_W-1:0] : memdata[LABEL_W-1:0];
    assign lbset_seen = (state == S_WORD0) && (scan_op == OP_LBSET);
    assign wr_en      = lbset_seen && !rd_valid;
    assign lookup     = exec_valid && scan_done && (exec_op == OP_PLIMM);

    assign pc_update_req  = lookup && rd_valid;
    assign pc_update_addr = (lookup && rd_valid) ? rd_addr : '0;

    label_table #(
        .LABEL_W (LABEL_W),
        .ADDR_W  (ADDR_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_id    (memdata[LABEL_W-1:0]),
        .wr_addr  (ptr_plus2[ADDR_W-1:0]),
        .rd_id    (rd_id),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RESET;
            scan_ptr <= '0;
        end else begin
            state    <= next_state;
            scan_ptr <= ptr_next;
        end
    end

    // The pointer stays on word 0 of a pair so the LBSET target is ptr+2.
    always_comb begin
        next_state = state;
        ptr_next   = scan_ptr;
        case (state)
            S_RESET: begin
                next_state = S_ADDR;
                ptr_next   = '0;
            end
            S_ADDR: next_state = S_WORD0;
            S_WORD0: begin
                if (is_two_word(scan_op)) begin
                    next_state = S_SKIP_ADDR;
                end else if ((scan_op == OP_HLT) || (scan_ptr == LAST_PTR)) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_ADDR;
                    ptr_next   = scan_ptr + ADDR_W'(1);
                end
            end
            S_SKIP_ADDR: next_state = S_SKIP_DATA;
            S_SKIP_DATA: begin
                if (ptr_plus2 >= DEPTH_EXT) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_ADDR;
                    ptr_next   = ptr_plus2[ADDR_W-1:0];
                end
            end
            S_DONE:  next_state = S_DONE;
            default: next_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            label_count <= '0;
            err_dup     <= 1'b0;
            err_undef   <= 1'b0;
        end else begin
            if (wr_en) begin
                label_count <= label_count + (LABEL_W + 1)'(1);
            end
            if (lbset_seen && rd_valid) begin
                err_dup <= 1'b1;
            end
            if (lookup && !rd_valid) begin
                err_undef <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_label_prescan.sv
// Directed bench for label_prescan: scan timing, table contents, error flags and PLIMM lookup.
module tb_label_prescan;
    import label_prescan_pkg::*;

    localparam int LABEL_W   = 8;
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 4096;

    typedef struct {
        logic        exec;
        logic [31:0] instr;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_undef;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        memdata = 32'h0;
    logic               scan_done;
    logic               cpu_reset;
    logic               exec_valid = 1'b0;
    logic [31:0]        instr0 = 32'h0;
    logic               pc_update_req;
    logic [ADDR_W-1:0]  pc_update_addr;
    logic [LABEL_W:0]   label_count;
    logic               err_dup;
    logic               err_undef;

    logic [31:0] mem [MEM_DEPTH];
    int checks = 0;
    int errors = 0;

    label_prescan #(
        .LABEL_W   (LABEL_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .memdata        (memdata),
        .scan_done      (scan_done),
        .cpu_reset      (cpu_reset),
        .exec_valid     (exec_valid),
        .instr0         (instr0),
        .pc_update_req  (pc_update_req),
        .pc_update_addr (pc_update_addr),
        .label_count    (label_count),
        .err_dup        (err_dup),
        .err_undef      (err_undef)
    );

    always #5 clk = ~clk;

    always @(posedge clk) memdata <= mem[mem_addr[11:0]];

    function automatic logic [31:0] mk(input logic [7:0] op, input int id);
        return {op, 16'h0000, 8'(id)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic exec, input logic [31:0] instr);
        exec_valid = exec;
        instr0     = instr;
    endtask

    task automatic clearMem();
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = mk(OP_NOP, 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_label_count"}, 32'(label_count), 32'd0);
        checkOutput({tag, "_err_dup"}, 32'(err_dup), 32'd0);
        checkOutput({tag, "_err_undef"}, 32'(err_undef), 32'd0);
        checkOutput({tag, "_pc_req"}, 32'(pc_update_req), 32'd0);
        checkOutput({tag, "_pc_addr"}, 32'(pc_update_addr), 32'd0);
    endtask

    // Releases reset at a negedge and counts cycles until scan_done is seen.
    task automatic runScan(input string tag, output int cycles, output bit spurious);
        cycles   = 0;
        spurious = 1'b0;
        reset    = 1'b0;
        while (cycles < 10000) begin
            @(negedge clk);
            cycles++;
            if (scan_done) break;
            if (pc_update_req || err_undef) spurious = 1'b1;
        end
        applyStimulus(1'b0, 32'h0);
        checkOutput({tag, "_scan_done_within_bound"}, 32'(scan_done), 32'd1);
    endtask

    task automatic checkLookup(input string name, input int id, input logic exp_req, input logic [15:0] exp_addr);
        applyStimulus(1'b1, mk(OP_PLIMM, id));
        #1;
        checkOutput({name, "_req"}, 32'(pc_update_req), 32'(exp_req));
        checkOutput({name, "_addr"}, 32'(pc_update_addr), 32'(exp_addr));
        @(negedge clk);
        applyStimulus(1'b0, 32'h0);
    endtask

    initial begin
        vec_t vecs [8];
        int   cycles;
        bit   spurious;

        vecs[0] = '{1'b1, mk(OP_PLIMM, 5),  1'b1, 16'h0003, 1'b0};
        vecs[1] = '{1'b0, mk(OP_PLIMM, 5),  1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, mk(OP_NOP, 5),    1'b0, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, mk(OP_LIMM32, 5), 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, mk(OP_PLIMM, 9),  1'b0, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 32'h03ABCD05,     1'b1, 16'h0003, 1'b0};
        vecs[6] = '{1'b1, mk(OP_PLIMM, 9),  1'b0, 16'h0000, 1'b1};
        vecs[7] = '{1'b1, mk(OP_PLIMM, 5),  1'b1, 16'h0003, 1'b1};

        // Basic scan with a PLIMM to an undefined label held during the scan.
        clearMem();
        mem[1] = mk(OP_LBSET, 5);
        mem[2] = 32'hDEADBEEF;
        mem[4] = mk(OP_HLT, 0);
        resetDut();
        checkResetValues("rst");
        applyStimulus(1'b1, mk(OP_PLIMM, 9));
        runScan("basic", cycles, spurious);
        checkOutput("basic_cycles", 32'(cycles), 32'd11);
        checkOutput("basic_exec_ignored", 32'(spurious), 32'd0);
        checkOutput("basic_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("basic_label_count", 32'(label_count), 32'd1);
        checkOutput("basic_err_dup", 32'(err_dup), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].exec, vecs[i].instr);
            #1;
            checkOutput($sformatf("vec%0d_req", i), 32'(pc_update_req), 32'(vecs[i].exp_req));
            checkOutput($sformatf("vec%0d_addr", i), 32'(pc_update_addr), 32'(vecs[i].exp_addr));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_err_undef", i), 32'(err_undef), 32'(vecs[i].exp_undef));
        end
        applyStimulus(1'b0, 32'h0);

        // LIMM32 data word carrying an LBSET opcode must be skipped.
        clearMem();
        mem[0] = mk(OP_LIMM32, 0);
        mem[1] = mk(OP_LBSET, 3);
        mem[2] = mk(OP_HLT, 0);
        resetDut();
        runScan("limm", cycles, spurious);
        checkOutput("limm_cycles", 32'(cycles), 32'd7);
        checkOutput("limm_label_count", 32'(label_count), 32'd0);
        checkLookup("limm_lookup3", 3, 1'b0, 16'h0000);

        // Duplicate definition keeps the first target.
        clearMem();
        mem[0] = mk(OP_LBSET, 7);
        mem[2] = mk(OP_LBSET, 7);
        mem[4] = mk(OP_HLT, 0);
        resetDut();
        runScan("dup", cycles, spurious);
        checkOutput("dup_cycles", 32'(cycles), 32'd11);
        checkOutput("dup_label_count", 32'(label_count), 32'd1);
        checkOutput("dup_err_dup", 32'(err_dup), 32'd1);
        checkLookup("dup_lookup7", 7, 1'b1, 16'h0002);

        // No HLT anywhere: scan ends on the last word.
        clearMem();
        resetDut();
        runScan("nohlt", cycles, spurious);
        checkOutput("nohlt_cycles", 32'(cycles), 32'd8193);
        checkOutput("nohlt_mem_addr", 32'(mem_addr), 32'(MEM_DEPTH - 1));
        checkOutput("nohlt_label_count", 32'(label_count), 32'd0);

        // Reset pulse during S_SKIP_DATA of the first LBSET, then a full rescan.
        clearMem();
        mem[0] = mk(OP_LBSET, 5);
        mem[2] = mk(OP_LBSET, 7);
        mem[4] = mk(OP_HLT, 0);
        resetDut();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_label_written", 32'(label_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("mid");
        runScan("rescan", cycles, spurious);
        checkOutput("rescan_cycles", 32'(cycles), 32'd11);
        checkOutput("rescan_label_count", 32'(label_count), 32'd2);
        checkOutput("rescan_err_dup", 32'(err_dup), 32'd0);
        checkLookup("rescan_lookup5", 5, 1'b1, 16'h0002);
        checkLookup("rescan_lookup7", 7, 1'b1, 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
